// File: rtl/runway_light_seq_pkg.sv
// runway_pkg: shared mode encoding and calm-phase pattern helper for runway_light_seq.
package runway_pkg;
  typedef enum logic [1:0] {
    MODE_CALM = 2'b00,
    MODE_RTL  = 2'b01,
    MODE_LTR  = 2'b10,
    MODE_GUST = 2'b11
  } mode_e;
  function automatic logic [31:0] calm_pattern(input logic phase, input int unsigned width);
    return (phase ? 32'hAAAA_AAAA : 32'h5555_5555) & (32'hFFFF_FFFF >> (32 - width));
  endfunction
endpackage

// File: rtl/runway_light_seq_tick_prescaler.sv
// tick_prescaler: one-cycle step strobe every TICK_DIV enabled cycles; count freezes while en is low.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] count;
  assign tick = en && count == CW'(TICK_DIV - 1);
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (tick) count <= '0;
    else if (en) count <= count + 1'b1;
  end
endmodule

// File: rtl/runway_light_seq.sv
// runway_light_seq: wind-dependent runway lamp sequencer (calm, sweeps, gust flash).
// Define RUNWAY_TRAIL_EN to light the previous sweep lamp as a 2-lamp comet.
module runway_light_seq
  import runway_pkg::*;
#(
  parameter int N_LAMPS  = 3,
  parameter int TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         w,
  output logic [N_LAMPS-1:0] out,
  output logic [1:0]         mode,
  output logic               sweep_done
);
  localparam int PW = $clog2(N_LAMPS);
`ifdef RUNWAY_TRAIL_EN
  localparam logic TRAIL = 1'b1;
`else
  localparam logic TRAIL = 1'b0;
`endif
  logic          tick;
  logic          wrap;
  logic [PW-1:0] pos;
  logic [PW-1:0] nxt;
  mode_e         cur;
  mode_e         wm;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .tick (tick)
  );
  // Trail only applies after a real step; a fresh mode entry shows the lead lamp alone.
  function automatic logic [N_LAMPS-1:0] pattern(input mode_e m, input logic [PW-1:0] p, input logic trail);
    logic [N_LAMPS-1:0] one;
    logic [N_LAMPS-1:0] lead;
    logic [N_LAMPS-1:0] prev;
    logic [PW-1:0]      q;
    one  = N_LAMPS'(1);
    q    = p == '0 ? PW'(N_LAMPS - 1) : p - 1'b1;
    lead = m == MODE_LTR ? one << (PW'(N_LAMPS - 1) - p) : one << p;
    prev = m == MODE_LTR ? one << (PW'(N_LAMPS - 1) - q) : one << q;
    return m == MODE_CALM ? N_LAMPS'(calm_pattern(p[0], N_LAMPS)) :
           m == MODE_GUST ? {N_LAMPS{~p[0]}} :
           lead | (trail ? prev : '0);
  endfunction
  assign wm   = mode_e'(w);
  assign wrap = pos == ((cur == MODE_CALM || cur == MODE_GUST) ? PW'(1) : PW'(N_LAMPS - 1));
  assign nxt  = wrap ? '0 : pos + 1'b1;
  assign mode = cur;
  always_ff @(posedge clk) begin
    if (reset) begin
      cur        <= MODE_CALM;
      pos        <= '0;
      out        <= pattern(MODE_CALM, '0, 1'b0);
      sweep_done <= 1'b0;
    end else if (tick && wm != cur) begin
      cur        <= wm;
      pos        <= '0;
      out        <= pattern(wm, '0, 1'b0);
      sweep_done <= 1'b0;
    end else if (tick) begin
      pos        <= nxt;
      out        <= pattern(cur, nxt, TRAIL);
      sweep_done <= wrap;
    end else begin
      sweep_done <= 1'b0;
    end
  end
endmodule

// File: doc/runway_light_seq.md
Name: runway_light_seq

Overview:
- Parametrised successor to the 3-lamp airport runway-light FSM.
- Drives N_LAMPS landing lights in wind-dependent patterns: calm alternation, right-to-left sweep, left-to-right sweep, and a new gust all-flash mode.
- Adds a step-rate prescaler, a run enable, a wrap indication and active-mode reporting.
- Sits between the wind-sensor decode and the lamp driver outputs.

Parameters:
- N_LAMPS, 3, number of lamps; legal range 2..32. out[0] is the rightmost lamp, out[N_LAMPS-1] the leftmost.
- TICK_DIV, 1, clock cycles per pattern step; legal range 1..65535. A value of 1 steps every cycle.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable; low freezes the prescaler and the pattern.
- w  in  2  wind code: 00 calm, 01 right-to-left, 10 left-to-right, 11 gust.
- out  out  N_LAMPS  lamp drive, registered.
- mode  out  2  currently active mode, registered; same encoding as w.
- sweep_done  out  1  one-cycle pulse when the pattern wraps to its start.

Behaviour:
- Reset: synchronous, active-high, on clk; effective at the first edge where reset=1, and it overrides en.
- Reset values:
  - mode=00 (calm).
  - out = calm phase A (bits at even indices set; 101 for N=3).
  - sweep_done=0; prescaler count=0; position index=0.
- Tick generation:
  - Internal tick=1 when en=1 and count==TICK_DIV-1. Count wraps to 0 on tick.
  - When en=1 and not tick, count increments.
  - When en=0, count holds and no tick occurs.
- All state and output updates happen only on a tick edge. Latency is one edge after the tick cycle. With TICK_DIV=1 and en=1, out changes every cycle.
- w is sampled only in tick cycles.
- Mode change (tick with w != mode):
  - mode<=w; position<=0; out<=start pattern of the new mode; sweep_done<=0.
  - A mode change on the same tick as a wrap: the new mode wins and no sweep_done is produced.
- Same mode (tick with w == mode): advance per mode.
  - CALM (00): toggle between phase A (even bits) and phase B (odd bits; 010 for N=3). Period 2 ticks. Start pattern = phase A.
  - RTL (01): one-hot lamp walks right to left. Positions 0..N_LAMPS-1 give out=1<<pos, so 001→010→100→001. Start pattern = bit 0.
  - LTR (10): one-hot lamp walks left to right. out=1<<(N_LAMPS-1-pos), so 100→010→001→100. Start pattern = bit N_LAMPS-1.
  - GUST (11): all-ones, then all-zeros, alternating. Start pattern = all-ones. Period 2 ticks.
- sweep_done:
  - Driven to 1 for exactly one cycle, on the edge where a same-mode advance returns out to that mode's start pattern (position wraps to 0).
  - It is 0 in every other cycle, including all non-tick cycles.
- State machine: one state register per mode (CALM, RTL, LTR, GUST) plus a position counter of width clog2(N_LAMPS). Position is 0/1 in CALM and GUST.
- en deasserted mid-sweep: out, mode and position hold. Stepping resumes from the held count when en returns to 1.
- Reset mid-sweep: reset values take effect at the next edge regardless of tick or en.

Optional Feature:
- Macro: RUNWAY_TRAIL_EN.
- Defined: in RTL and LTR, the lamp at the previous position is also lit, forming a 2-lamp comet.
  - The previous position for pos=0 is N_LAMPS-1 (wrap-around). For example, RTL with N=3 gives 101→011→110→101.
  - The start pattern after a mode change shows only the single lead lamp, because no previous step exists yet.
  - CALM and GUST are unaffected. sweep_done timing is unchanged.
- Undefined: plain one-hot sweep, as described in Behaviour.

Decomposition:
- Package runway_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_CALM=2'b00, MODE_RTL=2'b01, MODE_LTR=2'b10, MODE_GUST=2'b11};
  - the function calm_pattern(phase) parametrised on width.
- Sub-module tick_prescaler (parameter TICK_DIV; ports clk, reset, en, tick) generates the step strobe.
- The top level holds the mode/position FSM and the output register.

Test Plan:
- Reset, then N=3, TICK_DIV=1, en=1, w=00 for 4 cycles → out 101,010,101,010; sweep_done high on each return to 101.
- w=01 held for 5 cycles → out 001,010,100,001,010; mode=01; sweep_done pulses only on the cycle out returns to 001.
- While RTL out=010, switch w to 10 → next edge out=100, mode=10, no sweep_done; following edges give 010, 001, 100 with sweep_done at 100.
- TICK_DIV=4, w=11 → out toggles 111/000 every 4 cycles; drop en for 3 cycles mid-period → the step is delayed by exactly 3 cycles.
- Assert reset for one cycle mid-LTR sweep, with en=0 in the same cycle → out=101, mode=00, sweep_done=0 at the next edge.
- RUNWAY_TRAIL_EN defined, N=4, w=01 → out 0001,0011,0110,1100,1001, with sweep_done on 1001.
